// File: rtl/rx_probe_ctrl.sv
// MAC RX controller: tracks each frame, extracts the big-endian TX timestamp and emits the one-way delay.
// `RX_PROBE_JUMBO_EN` enables jumbo frames (max good length 9018 instead of 1518).
module rx_probe_ctrl #(
  parameter int TS_OFFSET    = 14,
  parameter int STAT_TIMEOUT = 16
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] time_now,
  output logic        conf_rx_en,
  output logic        conf_rx_no_chk_crc,
  output logic        conf_rx_jumbo_en,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_dvld,
  input  logic        mac_rx_goodframe,
  input  logic        mac_rx_badframe,
  output logic [31:0] rslt_delay,
  output logic [13:0] rslt_len,
  output logic        rslt_valid,
  input  logic        rslt_ready,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad,
  output logic [15:0] cnt_drop
);

`ifdef RX_PROBE_JUMBO_EN
  localparam int MAX_LEN = 9018;
`else
  localparam int MAX_LEN = 1518;
`endif
  localparam int          MIN_LEN = TS_OFFSET + 4;
  localparam logic [13:0] LEN_SAT = 14'h3FFF;
  localparam int          TW      = $clog2(STAT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_DISABLED = 3'd1,
    ST_IDLE     = 3'd2,
    ST_DATA     = 3'd3,
    ST_STATUS   = 3'd4,
    ST_SKIP     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   len_q, len_d;
  logic [31:0]   ts_q, ts_d;
  logic [31:0]   sof_q, sof_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   delay_q, delay_d;
  logic [13:0]   rlen_q, rlen_d;
  logic          valid_q, valid_d;
  logic [15:0]   good_q, good_d;
  logic [15:0]   bad_q, bad_d;
  logic [15:0]   drop_q, drop_d;

  logic          status_any;
  logic          tmo_last;
  logic          len_ok;
  logic          sof_take;
  logic          byte_take;
  logic          resolve;
  logic          skip_start;
  logic          frame_good;
  logic          frame_bad;
  logic          ts_byte;
  logic          rslt_ovf;
  logic [13:0]   byte_idx;

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign status_any = mac_rx_goodframe | mac_rx_badframe;
  assign tmo_last   = (tmo_q == TW'(STAT_TIMEOUT - 1));
  assign len_ok     = (int'(len_q) >= MIN_LEN) && (int'(len_q) <= MAX_LEN);

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:    state_d = ST_DISABLED;
      ST_DISABLED: if (enable) state_d = ST_IDLE;
      ST_IDLE: begin
        if (mac_rx_dvld)  state_d = ST_DATA;
        else if (!enable) state_d = ST_DISABLED;
      end
      ST_DATA:     if (!mac_rx_dvld) state_d = ST_STATUS;
      ST_STATUS: begin
        // A new frame arriving before status forces resolution and is itself skipped
        if (skip_start)   state_d = ST_SKIP;
        else if (resolve) state_d = enable ? ST_IDLE : ST_DISABLED;
      end
      ST_SKIP:     if (!mac_rx_dvld) state_d = enable ? ST_IDLE : ST_DISABLED;
      default:     state_d = ST_RESET;
    endcase
  end

  always_comb begin
    conf_rx_en = 1'b0;
    sof_take   = 1'b0;
    byte_take  = 1'b0;
    resolve    = 1'b0;
    skip_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        conf_rx_en = 1'b1;
        sof_take   = mac_rx_dvld;
        byte_take  = mac_rx_dvld;
      end
      ST_DATA: begin
        conf_rx_en = 1'b1;
        byte_take  = mac_rx_dvld;
      end
      ST_STATUS: begin
        conf_rx_en = 1'b1;
        resolve    = mac_rx_dvld | status_any | tmo_last;
        skip_start = mac_rx_dvld;
      end
      ST_SKIP:  conf_rx_en = 1'b1;
      default:  conf_rx_en = 1'b0;
    endcase
    frame_good = resolve && mac_rx_goodframe && !mac_rx_badframe && len_ok;
    frame_bad  = resolve && !frame_good;
  end

  always_comb begin
    len_d    = len_q;
    ts_d     = ts_q;
    sof_d    = sof_q;
    tmo_d    = tmo_q;
    byte_idx = sof_take ? 14'd0 : len_q;
    ts_byte  = byte_take && (int'(byte_idx) >= TS_OFFSET) && (int'(byte_idx) < TS_OFFSET + 4);
    if (ts_byte) begin
      ts_d = {ts_q[23:0], mac_rx_data};
    end
    if (sof_take) begin
      sof_d = time_now;
      len_d = 14'd1;
    end else if (byte_take && (len_q != LEN_SAT)) begin
      len_d = len_q + 14'd1;
    end
    if (state_q == ST_DATA) begin
      tmo_d = '0;
    end else if (state_q == ST_STATUS) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    delay_d  = delay_q;
    rlen_d   = rlen_q;
    valid_d  = valid_q;
    rslt_ovf = 1'b0;
    if (frame_good) begin
      // An unaccepted result is never overwritten; the newer one is dropped
      if (valid_q && !rslt_ready) begin
        rslt_ovf = 1'b1;
      end else begin
        delay_d = sof_q - ts_q;
        rlen_d  = len_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && rslt_ready) begin
      valid_d = 1'b0;
    end
    good_d = sat_inc(good_q, {1'b0, frame_good});
    bad_d  = sat_inc(bad_q, {1'b0, frame_bad});
    drop_d = sat_inc(drop_q, {1'b0, skip_start} + {1'b0, rslt_ovf});
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      len_q   <= '0;
      ts_q    <= '0;
      sof_q   <= '0;
      tmo_q   <= '0;
      delay_q <= '0;
      rlen_q  <= '0;
      valid_q <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
      drop_q  <= '0;
    end else begin
      len_q   <= len_d;
      ts_q    <= ts_d;
      sof_q   <= sof_d;
      tmo_q   <= tmo_d;
      delay_q <= delay_d;
      rlen_q  <= rlen_d;
      valid_q <= valid_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      drop_q  <= drop_d;
    end
  end

  assign conf_rx_no_chk_crc = 1'b0;
`ifdef RX_PROBE_JUMBO_EN
  assign conf_rx_jumbo_en = conf_rx_en;
`else
  assign conf_rx_jumbo_en = 1'b0;
`endif
  assign rslt_delay = delay_q;
  assign rslt_len   = rlen_q;
  assign rslt_valid = valid_q;
  assign cnt_good   = good_q;
  assign cnt_bad    = bad_q;
  assign cnt_drop   = drop_q;

endmodule

// File: tb/tb_rx_probe_ctrl.sv
// Bench for rx_probe_ctrl: frame-level reference model with a result scoreboard.
module tb_rx_probe_ctrl;
  localparam int TS_OFFSET    = 14;
  localparam int STAT_TIMEOUT = 16;
`ifdef RX_PROBE_JUMBO_EN
  localparam int   MAX_LEN = 9018;
  localparam logic JUMBO   = 1'b1;
`else
  localparam int   MAX_LEN = 1518;
  localparam logic JUMBO   = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] time_now = 32'd0;
  logic        conf_rx_en, conf_rx_no_chk_crc, conf_rx_jumbo_en;
  logic [7:0]  mac_rx_data = 8'd0;
  logic        mac_rx_dvld = 1'b0;
  logic        mac_rx_goodframe = 1'b0;
  logic        mac_rx_badframe = 1'b0;
  logic [31:0] rslt_delay;
  logic [13:0] rslt_len;
  logic        rslt_valid;
  logic        rslt_ready = 1'b0;
  logic [15:0] cnt_good, cnt_bad, cnt_drop;

  always #5 rx_clk = ~rx_clk;

  rx_probe_ctrl #(.TS_OFFSET(TS_OFFSET), .STAT_TIMEOUT(STAT_TIMEOUT)) dut (
    .rx_clk(rx_clk), .reset(reset), .enable(enable), .time_now(time_now),
    .conf_rx_en(conf_rx_en), .conf_rx_no_chk_crc(conf_rx_no_chk_crc),
    .conf_rx_jumbo_en(conf_rx_jumbo_en), .mac_rx_data(mac_rx_data),
    .mac_rx_dvld(mac_rx_dvld), .mac_rx_goodframe(mac_rx_goodframe),
    .mac_rx_badframe(mac_rx_badframe), .rslt_delay(rslt_delay), .rslt_len(rslt_len),
    .rslt_valid(rslt_valid), .rslt_ready(rslt_ready), .cnt_good(cnt_good),
    .cnt_bad(cnt_bad), .cnt_drop(cnt_drop)
  );

  typedef struct packed {
    logic [31:0] delay;
    logic [13:0] len;
  } res_t;

  res_t exp_q[$];
  res_t ld_exp;
  res_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_good = 0, m_bad = 0, m_drop = 0;
  bit   occ = 0, ld_now = 0, bad_now = 0, skip_now = 0;
  bit   rdy_rand = 0;
  logic rdy_fixed = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Result monitor: every handshake must match the oldest expected result
  always @(negedge rx_clk) begin
    if (!reset && rslt_valid && rslt_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: actual delay 0x%0h len %0d, expected no result", rslt_delay, rslt_len);
      end else begin
        mon_e = exp_q.pop_front();
        check("rslt_delay", {32'd0, rslt_delay}, {32'd0, mon_e.delay});
        check("rslt_len", {50'd0, rslt_len}, {50'd0, mon_e.len});
      end
    end
  end

  // One clock: the model sees exactly the inputs the DUT samples at this edge
  task automatic tick();
    rslt_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    @(posedge rx_clk);
    if (reset) begin
      occ = 0;
      exp_q.delete();
      m_good = 0;
      m_bad = 0;
      m_drop = 0;
    end else begin
      if (ld_now) begin
        m_good++;
        if (occ && !rslt_ready) m_drop++;
        else begin
          exp_q.push_back(ld_exp);
          occ = 1;
        end
      end else if (occ && rslt_ready) begin
        occ = 0;
      end
      if (bad_now)  m_bad++;
      if (skip_now) m_drop++;
    end
    ld_now = 0;
    bad_now = 0;
    skip_now = 0;
    #1;
    time_now = time_now + 32'd1;
    check("rslt_valid", {63'd0, rslt_valid}, {63'd0, occ});
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic g, input logic b);
    mac_rx_dvld = dv;
    mac_rx_data = d;
    mac_rx_goodframe = g;
    mac_rx_badframe = b;
    tick();
  endtask

  task automatic send_bytes(input int len, input logic [31:0] ts, input int en_off_at,
                            output logic [31:0] sof);
    logic [7:0] b;
    sof = time_now;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (i >= TS_OFFSET && i < TS_OFFSET + 4) b = ts[8*(TS_OFFSET + 3 - i) +: 8];
      if (i == en_off_at) enable = 1'b0;
      drive(1'b1, b, 1'b0, 1'b0);
    end
  endtask

  // kind: 0 good status, 1 bad status, 2 both, 3 no status (timeout)
  task automatic send_frame(input int len, input logic [31:0] ts, input int kind,
                            input int sdly, input int gap, input int en_off_at);
    logic [31:0] sof;
    int eff;
    bit good;
    send_bytes(len, ts, en_off_at, sof);
    eff  = (len > 16383) ? 16383 : len;
    good = (kind == 0) && (eff >= TS_OFFSET + 4) && (eff <= MAX_LEN);
    if (kind == 3) begin
      bad_now = 1;
      for (int i = 0; i < STAT_TIMEOUT + 4; i++) drive(1'b0, 8'd0, 1'b0, 1'b0);
    end else begin
      for (int i = 1; i < sdly; i++) drive(1'b0, 8'd0, 1'b0, 1'b0);
      ld_now = good;
      bad_now = !good;
      ld_exp.delay = sof - ts;
      ld_exp.len = 14'(eff);
      drive(1'b0, 8'd0, (kind == 0 || kind == 2), (kind == 1 || kind == 2));
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic check_counters();
    check("cnt_good", {48'd0, cnt_good}, {48'd0, sat16(m_good)});
    check("cnt_bad", {48'd0, cnt_bad}, {48'd0, sat16(m_bad)});
    check("cnt_drop", {48'd0, cnt_drop}, {48'd0, sat16(m_drop)});
  endtask

  task automatic check_reset_outputs();
    check("rst_conf_rx_en", {63'd0, conf_rx_en}, 64'd0);
    check("rst_no_chk_crc", {63'd0, conf_rx_no_chk_crc}, 64'd0);
    check("rst_jumbo_en", {63'd0, conf_rx_jumbo_en}, 64'd0);
    check("rst_rslt_delay", {32'd0, rslt_delay}, 64'd0);
    check("rst_rslt_len", {50'd0, rslt_len}, 64'd0);
    check_counters();
  endtask

  initial begin
    logic [31:0] sof, ts;
    int r, len, kind;

    // reset and bring-up
    enable = 1'b1;
    rdy_fixed = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 1'b0, 1'b0);
    check_reset_outputs();
    reset = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("conf_rx_en_after_1", {63'd0, conf_rx_en}, 64'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("conf_rx_en_after_2", {63'd0, conf_rx_en}, 64'd1);
    check("conf_rx_jumbo_en", {63'd0, conf_rx_jumbo_en}, {63'd0, JUMBO});

    // basic good frame
    time_now = 32'h1500;
    send_frame(64, 32'h0000_1000, 0, 2, 2, -1);
    check_counters();

    // bad status, short frame, missing status
    send_frame(64, 32'h0000_1000, 1, 2, 2, -1);
    send_frame(10, 32'h1234_5678, 0, 2, 2, -1);
    send_frame(40, 32'h1234_5678, 3, 2, 2, -1);
    check_counters();

    // result register backpressure
    rdy_fixed = 1'b0;
    send_frame(30, 32'hDEAD_BEEF, 0, 3, 2, -1);
    send_frame(50, 32'h0000_0001, 0, 2, 2, -1);
    check_counters();
    rdy_fixed = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0);

    // length boundaries
    send_frame(TS_OFFSET + 3, 32'hA5A5_0000, 0, 2, 1, -1);
    send_frame(TS_OFFSET + 4, 32'hFFFF_FFFF, 0, 2, 1, -1);
    send_frame(MAX_LEN, 32'h0102_0304, 0, 2, 1, -1);
    send_frame(MAX_LEN + 1, 32'h0102_0304, 0, 2, 1, -1);
    send_frame(2000, 32'h7000_0000, 0, 2, 2, -1);
    check_counters();
    check("jumbo_pin", {63'd0, conf_rx_jumbo_en}, {63'd0, JUMBO});

    // new frame during status: first frame resolved by that cycle's status, second skipped
    ts = 32'h0BAD_F00D;
    send_bytes(30, ts, -1, sof);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    ld_now = 1;
    ld_exp.delay = sof - ts;
    ld_exp.len = 14'd30;
    skip_now = 1;
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 29; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check_counters();

    // enable dropped mid-frame
    send_frame(40, 32'h0000_00FF, 0, 3, 0, 10);
    check("conf_rx_en_disabled", {63'd0, conf_rx_en}, 64'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("conf_rx_en_still_off", {63'd0, conf_rx_en}, 64'd0);
    check_counters();
    enable = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("conf_rx_en_reenabled", {63'd0, conf_rx_en}, 64'd1);

    // randomized traffic with random consumer backpressure
    rdy_rand = 1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (n % 20 == 5)  len = int'($urandom_range(MAX_LEN - 8, MAX_LEN + 8));
      else if (r < 8)   len = int'($urandom_range(10, 100));
      else              len = int'($urandom_range(16, 20));
      r = int'($urandom_range(0, 19));
      kind = (r < 12) ? 0 : (r < 15) ? 1 : (r < 17) ? 2 : 3;
      send_frame(len, $urandom, kind, int'($urandom_range(2, 12)), int'($urandom_range(1, 4)), -1);
      check_counters();
    end

    // reset mid-frame with a pending result
    rdy_rand = 0;
    rdy_fixed = 1'b0;
    send_frame(25, 32'h1111_2222, 0, 2, 1, -1);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    check_reset_outputs();
    reset = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("conf_rx_en_after_reset", {63'd0, conf_rx_en}, 64'd1);

    rdy_fixed = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'd0, 1'b0, 1'b0);
    check_counters();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_probe_ctrl.md
# rx_probe_ctrl

Receive-side controller for the delay tester's MAC RX port. It drives the MAC RX configuration pins and tracks each received frame through a state machine. It extracts a 32-bit transmit timestamp from good frames and computes the one-way delay against the local time base. Results go out through a one-entry valid/ready register, with saturating good/bad/drop statistics.

## Interface
- `TS_OFFSET`, 14: byte offset of big-endian 32-bit transmit timestamp within frame (byte 0 = first byte with `mac_rx_dvld`=1).
- `STAT_TIMEOUT`, 16: cycles allowed in STATUS for goodframe/badframe before frame is judged bad.
- `rx_clk`  in  1  RX clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = accept frames; 0 = disable RX after current frame.
- `time_now`  in  32  free-running local timestamp, `rx_clk` domain.
- `conf_rx_en`  out  1  MAC RX enable.
- `conf_rx_no_chk_crc`  out  1  constant 0 (MAC checks CRC).
- `conf_rx_jumbo_en`  out  1  see Configuration.
- `mac_rx_data`  in  8  RX byte.
- `mac_rx_dvld`  in  1  byte valid; high for whole frame.
- `mac_rx_goodframe`  in  1  one-cycle good-frame status after frame.
- `mac_rx_badframe`  in  1  one-cycle bad-frame status after frame.
- `rslt_delay`  out  32  `sof_time - tx_ts`, modulo 2^32.
- `rslt_len`  out  14  frame length in bytes.
- `rslt_valid`  out  1  result held until accepted.
- `rslt_ready`  in  1  consumer accepts when `rslt_valid & rslt_ready`.
- `cnt_good`, `cnt_bad`, `cnt_drop`  out  16 each  saturating statistics.

## Operation
- States: RESET, DISABLED, IDLE, DATA, STATUS, SKIP.
- RESET: entered on `reset`; one cycle; → DISABLED.
- DISABLED: `conf_rx_en`=0; `enable`=1 → IDLE.
- IDLE: `conf_rx_en`=1.
  - `mac_rx_dvld`=1 → DATA; that byte is byte 0; latch `sof_time`=`time_now`; length=1.
  - Else `enable`=0 → DISABLED.
- DATA: each `mac_rx_dvld`=1 cycle stores byte at index length if in TS_OFFSET..TS_OFFSET+3 (MSB first), then increments length.
  - Length saturates at 16383.
  - `mac_rx_dvld`=0 → STATUS; timeout counter cleared.
- STATUS: the first cycle with goodframe or badframe resolves the frame.
  - good only and length ≥ TS_OFFSET+4 and length ≤ max length: good. `cnt_good`++ and result produced.
  - Otherwise (badframe, both together, short, oversize): bad. `cnt_bad`++ and no result.
  - No status within STAT_TIMEOUT cycles: bad.
  - After resolution → IDLE, or DISABLED if `enable`=0.
  - `mac_rx_dvld`=1 while in STATUS: status sampled that cycle decides the frame (none = bad), then → SKIP.
- SKIP: ignore bytes; `mac_rx_dvld`=0 → IDLE/DISABLED. A skipped frame increments `cnt_drop` and no other counter; its trailing status is ignored.
- `enable` deasserted mid-frame: frame completes normally.
- Result register:
  - A good result loads `rslt_delay`/`rslt_len` and sets `rslt_valid`.
  - If `rslt_valid`=1 and `rslt_ready`=0 at load, the new result is discarded and `cnt_drop`++; old result is kept.
  - Accept and load in same cycle: new result loaded, `rslt_valid` stays 1.
- All counters saturate at 0xFFFF.

## Timing
- Reset values: all outputs 0; `rslt_delay`=0, `rslt_len`=0, counters 0; state RESET.
- `conf_rx_en` rises 2 cycles after `reset` falls with `enable`=1 (RESET, DISABLED, then IDLE).
- `conf_rx_en` falls the cycle after IDLE samples `enable`=0.
- `sof_time` = `time_now` in the cycle byte 0 is sampled.
- `rslt_valid` rises the cycle after the goodframe cycle.
- Counters update the cycle after resolution.
- `rslt_valid` falls the cycle after the `valid&ready` handshake, unless a new load occurs.

## Configuration
- `RX_PROBE_JUMBO_EN` defined:
  - `conf_rx_jumbo_en` = `conf_rx_en`.
  - Max good length 9018.
- Undefined:
  - `conf_rx_jumbo_en` = 0.
  - Max good length 1518; longer frames are counted bad even if the MAC reports goodframe.

## Test plan
- Reset, then `enable`=1: `conf_rx_en`=1 on 3rd cycle; `conf_rx_no_chk_crc`=0; all counters 0.
- 64-byte frame, timestamp bytes 00 00 10 00 at offset 14, `time_now`=0x1500 at byte 0, goodframe 2 cycles after: `rslt_delay`=0x500, `rslt_len`=64, `cnt_good`=1.
- Same frame with badframe, then 10-byte frame with goodframe, then frame with no status for 16 cycles: `cnt_bad`=3, no `rslt_valid`.
- Two good frames with `rslt_ready`=0: first result held, `cnt_drop`=1; then `rslt_ready`=1 for 1 cycle → `rslt_valid`=0.
- 2000-byte good frame: without macro → `cnt_bad`++ and `conf_rx_jumbo_en`=0; with `RX_PROBE_JUMBO_EN` → result with `rslt_len`=2000.
- `enable`=0 mid-frame: frame resolves good, then DISABLED with `conf_rx_en`=0; `reset` mid-frame → all outputs return to reset values next cycle.
